// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the architectural register file.
// Register 0 is architecturally hardwired to zero and never tracked.
package reg_file_pkg;

  localparam int REG_COUNT         = 32;
  localparam int REG_ID_W          = 5;
  localparam int DATA_W            = 32;
  localparam int ROB_WIDTH_BIT_DEF = 4;

  // A zero register id means "no write" on both commit and rename paths
  function automatic logic is_arch_reg(input logic [REG_ID_W-1:0] id);
    return id != '0;
  endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One decoder operand port: resolves a source register into a ready value
// or a pending ROB tag, bypassing same-cycle commits and ROB-held values.
module reg_read_port
  import reg_file_pkg::*;
#(
  parameter int ROB_WIDTH_BIT = ROB_WIDTH_BIT_DEF
) (
  input  logic [REG_ID_W-1:0]      i_get_reg,
  input  logic [DATA_W-1:0]        i_reg_value,
  input  logic                     i_reg_busy,
  input  logic [ROB_WIDTH_BIT-1:0] i_reg_tag,
  input  logic                     i_clear,
  input  logic [REG_ID_W-1:0]      i_commit_reg_id,
  input  logic [ROB_WIDTH_BIT-1:0] i_commit_rob_id,
  input  logic [DATA_W-1:0]        i_commit_val,
  input  logic                     i_rob_value_ready,
  input  logic [DATA_W-1:0]        i_rob_value,
  output logic [DATA_W-1:0]        o_val,
  output logic                     o_has_dep,
  output logic [ROB_WIDTH_BIT-1:0] o_dep,
  output logic [ROB_WIDTH_BIT-1:0] o_get_rob_id
);

  logic w_is_arch;
  logic w_pending;
  logic w_commit_hit;
  logic w_rob_hit;

  assign w_is_arch    = is_arch_reg(i_get_reg);
  assign w_pending    = w_is_arch && i_reg_busy;
  // A flush kills both the commit in flight and any ROB-held values
  assign w_commit_hit = !i_clear && (i_commit_reg_id == i_get_reg)
                        && (i_commit_rob_id == i_reg_tag);
  assign w_rob_hit    = !i_clear && i_rob_value_ready;

  always_comb begin
    o_val     = '0;
    o_has_dep = 1'b0;
    o_dep     = '0;
    if (!w_is_arch) begin
      o_val = '0;
    end else if (!i_reg_busy) begin
      o_val = i_reg_value;
    end else if (w_commit_hit) begin
      o_val = i_commit_val;
    end else if (w_rob_hit) begin
      o_val = i_rob_value;
    end else begin
      o_has_dep = 1'b1;
      o_dep     = i_reg_tag;
    end
  end

  assign o_get_rob_id = w_pending ? i_reg_tag : '0;

endmodule

// File: rtl/reg_file.sv
// Architectural register file with rename tags: commits retire ROB values,
// renames mark producers, and a flush drops every pending dependency.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int ROB_WIDTH_BIT = ROB_WIDTH_BIT_DEF
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear,
  input  logic [REG_ID_W-1:0]      set_reg_id,
  input  logic [DATA_W-1:0]        set_val,
  input  logic [ROB_WIDTH_BIT-1:0] set_reg_on_rob_id,
  input  logic [REG_ID_W-1:0]      set_dep_reg_id,
  input  logic [ROB_WIDTH_BIT-1:0] set_dep_rob_id,
  input  logic [REG_ID_W-1:0]      get_reg1,
  input  logic [REG_ID_W-1:0]      get_reg2,
  output logic [DATA_W-1:0]        val1,
  output logic [DATA_W-1:0]        val2,
  output logic                     has_dep1,
  output logic                     has_dep2,
  output logic [ROB_WIDTH_BIT-1:0] dep1,
  output logic [ROB_WIDTH_BIT-1:0] dep2,
  output logic [ROB_WIDTH_BIT-1:0] get_rob_id1,
  output logic [ROB_WIDTH_BIT-1:0] get_rob_id2,
  input  logic                     rob_value1_ready,
  input  logic                     rob_value2_ready,
  input  logic [DATA_W-1:0]        rob_value1,
  input  logic [DATA_W-1:0]        rob_value2
);

  logic [DATA_W-1:0]        r_value [REG_COUNT];
  logic                     r_busy  [REG_COUNT];
  logic [ROB_WIDTH_BIT-1:0] r_tag   [REG_COUNT];

  logic w_commit_en;
  logic w_rename_en;
  logic w_commit_retires;

  assign w_commit_en      = is_arch_reg(set_reg_id);
  assign w_rename_en      = is_arch_reg(set_dep_reg_id);
  // Only the youngest producer may clear busy; older commits just update value
  assign w_commit_retires = r_busy[set_reg_id] && (r_tag[set_reg_id] == set_reg_on_rob_id);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_value[i] <= '0;
        r_busy[i]  <= 1'b0;
        r_tag[i]   <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_busy[i] <= 1'b0;
        r_tag[i]  <= '0;
      end
    end else if (rdy_in) begin
      if (w_commit_en) begin
        r_value[set_reg_id] <= set_val;
        if (w_commit_retires) begin
          r_busy[set_reg_id] <= 1'b0;
        end
      end
      // Placed after the commit so a same-register rename wins busy/tag
      if (w_rename_en) begin
        r_busy[set_dep_reg_id] <= 1'b1;
        r_tag[set_dep_reg_id]  <= set_dep_rob_id;
      end
    end
  end

  reg_read_port #(.ROB_WIDTH_BIT(ROB_WIDTH_BIT)) u_port1 (
    .i_get_reg         (get_reg1),
    .i_reg_value       (r_value[get_reg1]),
    .i_reg_busy        (r_busy[get_reg1]),
    .i_reg_tag         (r_tag[get_reg1]),
    .i_clear           (clear),
    .i_commit_reg_id   (set_reg_id),
    .i_commit_rob_id   (set_reg_on_rob_id),
    .i_commit_val      (set_val),
    .i_rob_value_ready (rob_value1_ready),
    .i_rob_value       (rob_value1),
    .o_val             (val1),
    .o_has_dep         (has_dep1),
    .o_dep             (dep1),
    .o_get_rob_id      (get_rob_id1)
  );

  reg_read_port #(.ROB_WIDTH_BIT(ROB_WIDTH_BIT)) u_port2 (
    .i_get_reg         (get_reg2),
    .i_reg_value       (r_value[get_reg2]),
    .i_reg_busy        (r_busy[get_reg2]),
    .i_reg_tag         (r_tag[get_reg2]),
    .i_clear           (clear),
    .i_commit_reg_id   (set_reg_id),
    .i_commit_rob_id   (set_reg_on_rob_id),
    .i_commit_val      (set_val),
    .i_rob_value_ready (rob_value2_ready),
    .i_rob_value       (rob_value2),
    .o_val             (val2),
    .o_has_dep         (has_dep2),
    .o_dep             (dep2),
    .o_get_rob_id      (get_rob_id2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed scenarios with literal expectations, then
// random traffic checked every cycle against an array-based reference model.
module tb_reg_file;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear;
  logic [4:0]  set_reg_id, set_dep_reg_id, get_reg1, get_reg2;
  logic [31:0] set_val, rob_value1, rob_value2;
  logic [3:0]  set_reg_on_rob_id, set_dep_rob_id;
  logic        rob_value1_ready, rob_value2_ready;
  logic [31:0] val1, val2;
  logic        has_dep1, has_dep2;
  logic [3:0]  dep1, dep2, get_rob_id1, get_rob_id2;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] m_val  [32];
  logic        m_busy [32];
  logic [3:0]  m_tag  [32];

  always #5 clk_in = ~clk_in;

  reg_file #(.ROB_WIDTH_BIT(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .set_reg_id(set_reg_id), .set_val(set_val), .set_reg_on_rob_id(set_reg_on_rob_id),
    .set_dep_reg_id(set_dep_reg_id), .set_dep_rob_id(set_dep_rob_id),
    .get_reg1(get_reg1), .get_reg2(get_reg2),
    .val1(val1), .val2(val2), .has_dep1(has_dep1), .has_dep2(has_dep2),
    .dep1(dep1), .dep2(dep2), .get_rob_id1(get_rob_id1), .get_rob_id2(get_rob_id2),
    .rob_value1_ready(rob_value1_ready), .rob_value2_ready(rob_value2_ready),
    .rob_value1(rob_value1), .rob_value2(rob_value2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state transition, written straight from the register rules
  always @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
      end
    end else if (clear) begin
      for (int i = 0; i < 32; i++) begin
        m_busy[i] = 0; m_tag[i] = 0;
      end
    end else if (rdy_in) begin
      if (set_reg_id != 0) begin
        m_val[set_reg_id] = set_val;
        if (m_busy[set_reg_id] && m_tag[set_reg_id] == set_reg_on_rob_id)
          m_busy[set_reg_id] = 0;
      end
      if (set_dep_reg_id != 0) begin
        m_busy[set_dep_reg_id] = 1;
        m_tag[set_dep_reg_id]  = set_dep_rob_id;
      end
    end
  end

  task automatic model_read(input logic [4:0] r, input logic rr, input logic [31:0] rv,
                            output logic [31:0] v, output logic hd,
                            output logic [3:0] d, output logic [3:0] rid);
    v = 0; hd = 0; d = 0; rid = 0;
    if (r != 0) begin
      if (m_busy[r]) rid = m_tag[r];
      if (!m_busy[r])                                              v = m_val[r];
      else if (set_reg_id == r && set_reg_on_rob_id == m_tag[r])   v = set_val;
      else if (rr)                                                 v = rv;
      else begin hd = 1; d = m_tag[r]; end
    end
  endtask

  // Per-cycle comparison against the model; outputs during reset/flush are not checked
  always @(negedge clk_in) begin
    logic [31:0] ev; logic ehd; logic [3:0] ed, erid;
    if (rst_in === 1'b0 && clear === 1'b0) begin
      model_read(get_reg1, rob_value1_ready, rob_value1, ev, ehd, ed, erid);
      chk("m_val1", val1, ev);
      chk("m_has_dep1", 32'(has_dep1), 32'(ehd));
      chk("m_dep1", 32'(dep1), 32'(ed));
      chk("m_rob_id1", 32'(get_rob_id1), 32'(erid));
      model_read(get_reg2, rob_value2_ready, rob_value2, ev, ehd, ed, erid);
      chk("m_val2", val2, ev);
      chk("m_has_dep2", 32'(has_dep2), 32'(ehd));
      chk("m_dep2", 32'(dep2), 32'(ed));
      chk("m_rob_id2", 32'(get_rob_id2), 32'(erid));
    end
  end

  task automatic idle();
    rst_in = 0; rdy_in = 1; clear = 0;
    set_reg_id = 0; set_val = 0; set_reg_on_rob_id = 0;
    set_dep_reg_id = 0; set_dep_rob_id = 0;
    get_reg1 = 0; get_reg2 = 0;
    rob_value1_ready = 0; rob_value2_ready = 0; rob_value1 = 0; rob_value2 = 0;
  endtask

  task automatic step();
    @(posedge clk_in); #1;
  endtask

  task automatic rename(input logic [4:0] r, input logic [3:0] t);
    idle(); set_dep_reg_id = r; set_dep_rob_id = t; step();
  endtask

  task automatic commit(input logic [4:0] r, input logic [3:0] t, input logic [31:0] v);
    idle(); set_reg_id = r; set_reg_on_rob_id = t; set_val = v; step();
  endtask

  initial begin
    idle(); rst_in = 1;
    step(); step();

    // Reset state
    idle(); get_reg1 = 5;
    @(negedge clk_in);
    chk("rst_val1", val1, 32'h0);
    chk("rst_has_dep1", 32'(has_dep1), 32'h0);
    chk("rst_rob_id1", 32'(get_rob_id1), 32'h0);
    step();

    // Rename then ROB forwarding
    rename(5, 3);
    idle(); get_reg1 = 5;
    @(negedge clk_in);
    chk("ren_has_dep1", 32'(has_dep1), 32'h1);
    chk("ren_dep1", 32'(dep1), 32'h3);
    chk("ren_rob_id1", 32'(get_rob_id1), 32'h3);
    rob_value1_ready = 1; rob_value1 = 32'h1234; #1;
    chk("fwd_val1", val1, 32'h1234);
    chk("fwd_has_dep1", 32'(has_dep1), 32'h0);
    step();

    // Stale commit must not retire a newer producer
    rename(5, 7);
    commit(5, 3, 32'hAA);
    idle(); get_reg1 = 5;
    @(negedge clk_in);
    chk("stale_has_dep1", 32'(has_dep1), 32'h1);
    chk("stale_dep1", 32'(dep1), 32'h7);
    step();
    commit(5, 7, 32'hBB);
    idle(); get_reg1 = 5;
    @(negedge clk_in);
    chk("retire_val1", val1, 32'hBB);
    chk("retire_has_dep1", 32'(has_dep1), 32'h0);
    step();

    // Same-cycle commit bypass
    rename(6, 2);
    idle(); set_reg_id = 6; set_reg_on_rob_id = 2; set_val = 32'h55; get_reg2 = 6;
    @(negedge clk_in);
    chk("byp_val2", val2, 32'h55);
    chk("byp_has_dep2", 32'(has_dep2), 32'h0);
    step();

    // x0 writes ignored; commit+rename same register
    idle(); set_val = 32'h77; set_reg_on_rob_id = 5; set_dep_rob_id = 5;
    step();
    idle(); get_reg1 = 0;
    @(negedge clk_in);
    chk("x0_val1", val1, 32'h0);
    chk("x0_has_dep1", 32'(has_dep1), 32'h0);
    step();
    rename(9, 4);
    idle(); set_reg_id = 9; set_reg_on_rob_id = 4; set_val = 32'h9A;
    set_dep_reg_id = 9; set_dep_rob_id = 6; step();
    idle(); get_reg1 = 9;
    @(negedge clk_in);
    chk("both_has_dep1", 32'(has_dep1), 32'h1);
    chk("both_dep1", 32'(dep1), 32'h6);
    step();

    // Flush discards the same-cycle commit and all dependencies
    commit(4, 0, 32'h44);
    rename(4, 1);
    rename(8, 2);
    idle(); clear = 1; set_reg_id = 4; set_reg_on_rob_id = 1; set_val = 32'h99; step();
    idle(); get_reg1 = 4; get_reg2 = 8;
    @(negedge clk_in);
    chk("clr_val1", val1, 32'h44);
    chk("clr_has_dep1", 32'(has_dep1), 32'h0);
    chk("clr_has_dep2", 32'(has_dep2), 32'h0);
    step();
    idle(); get_reg1 = 9;
    @(negedge clk_in);
    chk("clr_x9_val1", val1, 32'h9A);
    step();

    // Frozen when not ready
    idle(); rdy_in = 0; set_dep_reg_id = 10; set_dep_rob_id = 5;
    set_reg_id = 10; set_reg_on_rob_id = 5; set_val = 32'h10; step();
    idle(); get_reg1 = 10;
    @(negedge clk_in);
    chk("frz_has_dep1", 32'(has_dep1), 32'h0);
    chk("frz_val1", val1, 32'h0);
    step();

    // Random traffic on a narrow register window to force collisions
    for (int i = 0; i < 3000; i++) begin
      rst_in            = ($urandom_range(0, 299) == 0);
      clear             = ($urandom_range(0, 24) == 0);
      rdy_in            = ($urandom_range(0, 9) != 0);
      set_reg_id        = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      set_reg_on_rob_id = 4'($urandom_range(0, 3));
      set_val           = $urandom;
      set_dep_reg_id    = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      set_dep_rob_id    = 4'($urandom_range(0, 3));
      get_reg1          = 5'($urandom_range(0, 7));
      get_reg2          = 5'($urandom);
      rob_value1_ready  = ($urandom_range(0, 2) == 0);
      rob_value2_ready  = ($urandom_range(0, 2) == 0);
      rob_value1        = $urandom;
      rob_value2        = $urandom;
      step();
    end

    idle(); step(); step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file with per-register rename tags, sitting directly downstream of the reorder buffer's commit/rename outputs and upstream of the decoder's operand fetch. It holds x0–x31 values, records which ROB entry will produce each register's next value, and retires values when the ROB commits. It resolves decoder operand queries into either a ready value or a ROB dependency tag, forwarding through the ROB's value lookup. On a mispredict flush it discards all pending dependencies.

## Interface
- ROB_WIDTH_BIT, default `ROB_WIDTH_BIT (4): width of a ROB entry id.

- clk_in  in  1  system clock
- rst_in  in  1  reset; synchronous, active-high
- rdy_in  in  1  global ready; state frozen when low
- clear  in  1  flush from ROB; drop all dependencies
- set_reg_id  in  5  commit destination register; 0 = no commit
- set_val  in  32  commit value
- set_reg_on_rob_id  in  ROB_WIDTH_BIT  ROB id of committing entry
- set_dep_reg_id  in  5  rename destination register; 0 = no rename
- set_dep_rob_id  in  ROB_WIDTH_BIT  ROB id now owning set_dep_reg_id
- get_reg1, get_reg2  in  5  decoder source register indices
- val1, val2  out  32  operand value, valid when has_dep* = 0
- has_dep1, has_dep2  out  1  operand still pending in ROB
- dep1, dep2  out  ROB_WIDTH_BIT  pending ROB id; 0 when has_dep* = 0
- get_rob_id1, get_rob_id2  out  ROB_WIDTH_BIT  ROB lookup index (tag of get_reg*)
- rob_value1_ready, rob_value2_ready  in  1  ROB entry value available
- rob_value1, rob_value2  in  32  ROB entry value

## Operation
- State per register i (1..31): value[i] 32b, busy[i] 1b, tag[i] ROB_WIDTH_BIT. x0 not stored: reads value 0, never busy; writes/renames to 0 ignored.
- Commit (set_reg_id ≠ 0): value[rd] <= set_val; busy[rd] <= 0 only if busy[rd] && tag[rd] == set_reg_on_rob_id, else busy/tag untouched (newer producer still in flight).
- Rename (set_dep_reg_id ≠ 0): busy[rd] <= 1, tag[rd] <= set_dep_rob_id.
- Commit and rename same register, same cycle: value written; rename wins for busy/tag.
- clear = 1: all busy <= 0, tags <= 0; commit and rename in that cycle discarded (wrong-path); values retained.
- rdy_in = 0: no state update (clear and rst_in still apply).
- Read port k (combinational, priority order):
  1. get_regk == 0 → val 0, has_dep 0.
  2. !busy → val = value, has_dep 0.
  3. busy and commit this cycle with set_reg_id == get_regk and set_reg_on_rob_id == tag → val = set_val, has_dep 0.
  4. busy and rob_valuek_ready → val = rob_valuek, has_dep 0.
  5. else val 0, has_dep 1, dep = tag.
- get_rob_idk = tag[get_regk] (0 when not busy or x0).
- Same-cycle rename never affects reads (an instruction's own rd is not its source).
- Read bypass disabled while clear = 1 (step 3 skipped; ROB values suppressed by flush).

## Timing
- Reset (rst_in high at posedge): all value/busy/tag = 0; outputs then val* = 0, has_dep* = 0, dep* = 0, get_rob_id* = 0.
- Writes take effect at the next posedge; reads are zero-latency combinational with same-cycle commit bypass.
- Rename at edge N visible to reads from cycle N+1.
- clear asserted cycle N: from N+1 every register reads non-busy.
- Reset mid-operation overrides clear, commit and rename.

## Structure
- ROB_WIDTH_BIT stays in const.v; add `REG_COUNT (32) there.
- One sub-module natural: reg_read_port (priority mux of steps 1–5), instantiated twice.

## Test plan
- Reset then get_reg1 = 5 → val1 = 0, has_dep1 = 0, get_rob_id1 = 0.
- Rename x5→ROB 3; next cycle get_reg1 = 5, rob_value1_ready = 0 → has_dep1 = 1, dep1 = 3, get_rob_id1 = 3; drive rob_value1_ready = 1, rob_value1 = 0x1234 → val1 = 0x1234, has_dep1 = 0.
- Rename x5→3 then x5→7; commit x5 = 0xAA from ROB 3 → value updated, read shows has_dep = 1, dep = 7; commit from ROB 7 with 0xBB → reads 0xBB, not busy.
- Same cycle commit x6 = 0x55 (ROB 2, tag 2) and get_reg2 = 6 → val2 = 0x55, has_dep2 = 0 that cycle.
- Commit and rename x0 (set_reg_id = 0, set_dep_reg_id = 0 with values) → x0 reads 0, never busy; simultaneous commit+rename x9 (commit tag matches) → x9 busy with new tag, value updated.
- x4, x8 busy; clear = 1 with a commit x4 = 0x99 same cycle → next cycle both non-busy, x4 keeps old value; rdy_in = 0 with rename x10 → x10 unchanged.
